m20k_prefetch_fifo: RTL

- Single-clock FIFO built on one MEMORY_M20K instance.
- This block is the read-end controller for that memory. It tracks the M20K write-to-read hazard and the 3-cycle registered read latency.
- It prefetches words into a small register queue and presents them as a ready/valid show-ahead stream.
- Used wherever pipeline stages buffer bursts into block RAM and drain them with backpressure.

---
 rtl/m20k_prefetch_fifo_pkg.sv | 11 +
 rtl/m20k_prefetch_fifo_m20k.sv | 49 ++++
 rtl/m20k_prefetch_fifo_queue.sv | 52 +++++
 rtl/m20k_prefetch_fifo.sv | 121 ++++++++++++
 4 files changed

// File: rtl/m20k_prefetch_fifo_pkg.sv
// Shared memory timing constants for block-RAM and MLAB consumers.
package m20k_prefetch_fifo_pkg;

  // Cycles from readEnable/readAddr to valid M20K dataOut (registered read).
  localparam int unsigned M20K_READ_LATENCY  = 3;
  // Cycles from an accepted write until the word may be read back safely.
  localparam int unsigned M20K_WRITE_TO_READ = 2;
  // Registered-output MLAB read latency, for other memory consumers.
  localparam int unsigned MLAB_READ_LATENCY  = 1;

endpackage

// File: rtl/m20k_prefetch_fifo_m20k.sv
// Behavioural MEMORY_M20K wrapper: registered write port, 3-cycle registered read.
module m20k_prefetch_fifo_m20k
  import m20k_prefetch_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic [DEPTH_LOG2-1:0] writeAddr,
  input  logic [WIDTH-1:0]      writeData,
  input  logic                  readEnable,
  input  logic [DEPTH_LOG2-1:0] readAddr,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  eccStatus
);

  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [WORDS];
  logic                  wrValid;
  logic [DEPTH_LOG2-1:0] wrAddr;
  logic [WIDTH-1:0]      wrData;
  logic [WIDTH-1:0]      rdPipe [M20K_READ_LATENCY];

  // Input write register; the array is updated one cycle after the port.
  always_ff @(posedge clk) begin
    if (rst) wrValid <= 1'b0;
    else     wrValid <= writeEnable;
    wrAddr <= writeAddr;
    wrData <= writeData;
  end

  // Array write from the registered write port.
  always_ff @(posedge clk) begin
    if (wrValid) mem[wrAddr] <= wrData;
  end

  // Registered read pipeline.
  always_ff @(posedge clk) begin
    if (readEnable) rdPipe[0] <= mem[readAddr];
    for (int unsigned i = 1; i < M20K_READ_LATENCY; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign dataOut   = rdPipe[M20K_READ_LATENCY-1];
  assign eccStatus = 1'b0;

endmodule

// File: rtl/m20k_prefetch_fifo_queue.sv
// Register-based circular queue with enqueue and ready/valid show-ahead pop.
module fifo_output_queue #(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enqueue,
  input  logic [WIDTH-1:0]      enqueueData,
  input  logic                  dataOutReady,
  output logic                  dataOutValid,
  output logic [WIDTH-1:0]      dataOut,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      buffer [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic                  pop;

  assign dataOutValid = (count != '0);
  assign dataOut      = buffer[head];
  assign pop          = dataOutValid & dataOutReady;

  // Entry storage at the tail.
  always_ff @(posedge clk) begin
    if (enqueue) buffer[tail] <= enqueueData;
  end

  // Head/tail pointers and occupancy; simultaneous enqueue and pop both apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enqueue) tail <= tail + 1'b1;
      if (pop)     head <= head + 1'b1;
      unique case ({enqueue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  queueNoOverflow: assert property (@(posedge clk) disable iff (rst)
    !(enqueue && !pop && (count == (DEPTH_LOG2+1)'(DEPTH))));

endmodule

// File: rtl/m20k_prefetch_fifo.sv
// M20K-backed FIFO read-end controller with prefetch queue and show-ahead output.
module m20k_prefetch_fifo
  import m20k_prefetch_fifo_pkg::*;
#(
  parameter int unsigned WIDTH              = 20,
  parameter int unsigned DEPTH_LOG2         = 9,
  parameter int unsigned QUEUE_DEPTH_LOG2   = 3,
  parameter int unsigned ALMOST_FULL_MARGIN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic [WIDTH-1:0]      dataIn,
  output logic                  full,
  output logic                  almostFull,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  dataOutValid,
  output logic [WIDTH-1:0]      dataOut,
  input  logic                  dataOutReady,
  output logic                  overflow,
  output logic                  eccStatus
);

  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
  localparam int unsigned QD    = 2 ** QUEUE_DEPTH_LOG2;
  localparam int unsigned UW    = DEPTH_LOG2 + 1;
  localparam int unsigned CW    = QUEUE_DEPTH_LOG2 + 2;

  logic [DEPTH_LOG2-1:0]         writePtr;
  logic [DEPTH_LOG2-1:0]         readPtr;
  logic [UW-1:0]                 usedwNext;
  logic [UW-1:0]                 availCount;
  logic [UW-1:0]                 availEff;
  logic [M20K_WRITE_TO_READ-1:0] availPipe;
  logic [M20K_READ_LATENCY-1:0]  inFlight;
  logic [CW-1:0]                 inFlightCount;
  logic [CW-1:0]                 occupancy;
  logic [QUEUE_DEPTH_LOG2:0]     queueCount;
  logic [WIDTH-1:0]              memDataOut;
  logic                          memEcc;
  logic                          accept;
  logic                          pop;
  logic                          issue;

  assign accept = writeEnable & ~full;
  assign pop    = dataOutValid & dataOutReady;

  m20k_prefetch_fifo_m20k #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_m20k (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (accept),
    .writeAddr   (writePtr),
    .writeData   (dataIn),
    .readEnable  (issue),
    .readAddr    (readPtr),
    .dataOut     (memDataOut),
    .eccStatus   (memEcc)
  );

  fifo_output_queue #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (QUEUE_DEPTH_LOG2)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .enqueue      (inFlight[M20K_READ_LATENCY-1]),
    .enqueueData  (memDataOut),
    .dataOutReady (dataOutReady),
    .dataOutValid (dataOutValid),
    .dataOut      (dataOut),
    .count        (queueCount)
  );

  // Read-issue credit and next occupancy.
  // The last availability stage is added combinationally so a word written in
  // cycle 0 can be issued in cycle 2, matching the write-to-read hazard window.
  always_comb begin
    inFlightCount = '0;
    for (int unsigned i = 0; i < M20K_READ_LATENCY; i++)
      inFlightCount = inFlightCount + CW'(inFlight[i]);
    occupancy = inFlightCount + CW'(queueCount);
    availEff  = availCount + UW'(availPipe[M20K_WRITE_TO_READ-1]);
    issue     = (availEff != '0) && ((occupancy - CW'(pop)) < CW'(QD));
    unique case ({accept, pop})
      2'b10:   usedwNext = usedw + 1'b1;
      2'b01:   usedwNext = usedw - 1'b1;
      default: usedwNext = usedw;
    endcase
  end

  // Pointers, availability pipe, in-flight marks, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      writePtr   <= '0;
      readPtr    <= '0;
      availPipe  <= '0;
      availCount <= '0;
      inFlight   <= '0;
      usedw      <= '0;
      full       <= 1'b0;
      almostFull <= 1'b0;
      overflow   <= 1'b0;
      eccStatus  <= 1'b0;
    end else begin
      if (accept) writePtr <= writePtr + 1'b1;
      if (issue)  readPtr  <= readPtr + 1'b1;
      availPipe  <= {availPipe[M20K_WRITE_TO_READ-2:0], accept};
      availCount <= availEff - UW'(issue);
      inFlight   <= {inFlight[M20K_READ_LATENCY-2:0], issue};
      usedw      <= usedwNext;
      full       <= (usedwNext == UW'(WORDS));
      almostFull <= ((UW'(WORDS) - usedwNext) <= UW'(ALMOST_FULL_MARGIN));
      if (writeEnable && full) overflow <= 1'b1;
      if (memEcc) eccStatus <= 1'b1;
    end
  end

endmodule
